lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu -- load/store unit between the execute stage and a simple word bus.
//
// Accepts one load or store at a time from the EXU, issues a single
// word-aligned bus request, and returns the load result to the write-back
// unit. Each request goes through the states IDLE -> REQ -> RESP -> IDLE.
//
// Parameters
//   BUS_TIMEOUT  REQ cycles without mem_ack before a bus error (1..255)
//
// Optional feature (compile-time macro)
//   LSU_MISALIGN_CHECK_EN  when defined, a misaligned halfword or word access
//                          skips the bus and is reported with misalign=1.
//                          When undefined, misalign is tied to 0, words ignore
//                          addr[1:0] and halfwords ignore addr[0].
//
// Ports
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   in_valid/in_ready           EXU request handshake
//   in_we, in_funct3            store flag, access size (B/H/W/BU/HU)
//   in_addr, in_wdata, in_rd    byte address, right-aligned store data, load rd
//   out_valid/out_ready         WBU result handshake
//   gpr_waddr/wdata/wen         register-write request to the WBU
//   mem_req, mem_we, mem_addr   bus request, write flag, word address
//   mem_wdata, mem_wstrb        lane-shifted store data and byte strobes
//   mem_ack, mem_rdata          bus acknowledge and read word
//   bus_err, misalign           error flags, valid only with out_valid
// ----------------------------------------------------------------------------
module lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_we,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        gpr_wen,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [1:0]  off_q,       off_d;
    logic [4:0]  rd_q,        rd_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] gpr_wdata_q, gpr_wdata_d;
    logic        bus_err_q,   bus_err_d;
    logic        misalign_q,  misalign_d;

    // Request decode. funct3[1:0] selects the size; 011/110/111 fall into
    // the word case. off_in is the byte lane actually used, so halfwords
    // and words drop the address bits they are allowed to ignore.
    logic        is_b, is_h, mis_in;
    logic [1:0]  off_in;
    logic [3:0]  wstrb_in;
    logic [31:0] lane, load_data;

    always_comb begin
        is_b   = (in_funct3[1:0] == 2'b00);
        is_h   = (in_funct3[1:0] == 2'b01);
        off_in = is_b ? in_addr[1:0] : (is_h ? {in_addr[1], 1'b0} : 2'b00);
`ifdef LSU_MISALIGN_CHECK_EN
        mis_in = (is_h && in_addr[0]) || (!is_b && !is_h && (in_addr[1:0] != 2'b00));
`else
        mis_in = 1'b0;
`endif
        if (!in_we)    wstrb_in = 4'b0000;
        else if (is_b) wstrb_in = 4'b0001 << off_in;
        else if (is_h) wstrb_in = 4'b0011 << off_in;
        else           wstrb_in = 4'b1111;
    end

    // Load extraction from the registered lane offset; funct3[2] = unsigned.
    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}},  lane[7:0]};
            3'b100:  load_data = {24'h0,          lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_data = {16'h0,          lane[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // NOTE: every _d gets its hold value first, so no path through the
    // case below can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        gpr_wdata_d = gpr_wdata_q;
        bus_err_d   = bus_err_q;
        misalign_d  = misalign_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    funct3_d    = in_funct3;
                    off_d       = off_in;
                    rd_d        = in_rd;
                    mem_we_d    = in_we;
                    mem_addr_d  = {in_addr[31:2], 2'b00};
                    mem_wdata_d = in_we ? (in_wdata << {off_in, 3'b000}) : 32'h0;
                    mem_wstrb_d = wstrb_in;
                    gpr_wdata_d = 32'h0;
                    bus_err_d   = 1'b0;
                    misalign_d  = mis_in;
                    cnt_d       = 8'd0;
                    // A misaligned access never touches the bus.
                    state_d     = mis_in ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    gpr_wdata_d = mem_we_q ? 32'h0 : load_data;
                    state_d     = S_RESP;
                end else if (cnt_q == 8'(BUS_TIMEOUT - 1)) begin
                    // This was the last allowed REQ cycle.
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            gpr_wdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            gpr_wdata_q <= gpr_wdata_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_RESP);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign gpr_waddr = rd_q;
    assign gpr_wdata = gpr_wdata_q;
    assign bus_err   = out_valid & bus_err_q;
    assign misalign  = out_valid & misalign_q;
    assign gpr_wen   = out_valid & ~mem_we_q & ~bus_err_q & ~misalign_q & (rd_q != 5'd0);

endmodule
